// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the RV32I lab CPU.
//
// Steps each instruction through INIT/IF/ID/EX/MEM/WB over the shared
// datapath. It drives the datapath mux selects and write strobes as
// combinational decodes of the current state and IR. An illegal opcode
// parks the FSM in HALT until reset.
//
// Ports:
//   clk, rstn            clock (rising edge), async active-low reset
//   ir                   current instruction register contents
//   br_taken             branch comparator result (sampled in EX)
//   imem_rdy, dmem_rdy   memory handshake completion
//   imem_req, dmem_req, dmem_we   memory requests
//   ir_we, pc_we, rf_we  datapath write strobes
//   pc_sel, wb_sel, alu_a_sel, alu_b_sel, alu_op   datapath selects
//   halted               illegal-opcode halt flag
//   instret              retired instruction count (wraps)
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      ir,
    input  logic             br_taken,
    input  logic             imem_rdy,
    input  logic             dmem_rdy,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic [3:0]       alu_op,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_INIT, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       ir_unused;

    logic       is_load, is_store, is_branch, is_jal, is_jalr, is_legal;
    logic [1:0] dec_a_sel;
    logic       dec_b_sel;
    logic [3:0] dec_alu_op;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign f7b5   = ir[30];
    // Register and immediate fields belong to the datapath, not to control.
    assign ir_unused = ^{ir[31], ir[29:15], ir[11:7]};

    // funct3 -> ALU operation; f7[5] selects SUB/SRA variants.
    function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);

    always_comb begin
        dec_a_sel  = 2'd0;
        dec_b_sel  = 1'b0;
        dec_alu_op = ALU_ADD;
        is_legal   = 1'b1;
        case (opcode)
            OP_ALU:   dec_alu_op = f3_to_op(funct3, f7b5);
            OP_IMM: begin
                dec_b_sel = 1'b1;
                // bit 30 is immediate data for ADDI, so never treat it as SUB.
                dec_alu_op = (funct3 == 3'b000) ? ALU_ADD : f3_to_op(funct3, f7b5);
            end
            OP_LUI: begin
                dec_a_sel = 2'd2;
                dec_b_sel = 1'b1;
            end
            OP_AUIPC: begin
                dec_a_sel = 2'd1;
                dec_b_sel = 1'b1;
            end
            OP_LOAD, OP_STORE, OP_JALR: dec_b_sel = 1'b1;
            OP_BRANCH, OP_JAL: ;
            default: is_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        alu_op    = ALU_ADD;
        halted    = 1'b0;
        // The ALU result must stay stable until it is consumed in MEM/WB.
        if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
            alu_a_sel = dec_a_sel;
            alu_b_sel = dec_b_sel;
            alu_op    = dec_alu_op;
        end
        case (state_q)
            S_INIT: state_d = S_IF;
            S_IF: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    ir_we   = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: state_d = is_legal ? S_EX : S_HALT;
            S_EX: begin
                if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = br_taken ? 2'd1 : 2'd0;
                    state_d = S_IF;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_rdy) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                wb_sel  = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
                pc_sel  = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
                state_d = S_IF;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    // Every PC update marks exactly one retired instruction.
    always_comb begin
        instret_d = instret_q;
        if (pc_we) instret_d = instret_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_INIT;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. Each driven cycle pushes the
// expected output vector to a scoreboard queue; a negedge monitor pops and
// compares it with the DUT outputs.
module tb_mc_ctrl;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_BR    = 3;
    localparam int K_JAL   = 4;
    localparam int K_JALR  = 5;
    localparam int K_ILL   = 6;

    typedef struct packed {
        logic        imem_req;
        logic        dmem_req;
        logic        dmem_we;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic [1:0]  alu_a_sel;
        logic        alu_b_sel;
        logic [3:0]  alu_op;
        logic        halted;
        logic [31:0] instret;
    } out_t;

    logic        clk;
    logic        rstn;
    logic [31:0] ir;
    logic        br_taken, imem_rdy, dmem_rdy;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_b_sel, halted;
    logic [1:0]  pc_sel, wb_sel, alu_a_sel;
    logic [3:0]  alu_op;
    logic [31:0] instret;

    out_t        obs;
    out_t        exp_q[$];
    out_t        msk_q[$];
    string       tag_q[$];
    logic [31:0] exp_instret;
    int          n_checks;
    int          n_errors;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .ir(ir), .br_taken(br_taken),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_op(alu_op), .halted(halted), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
                  wb_sel, alu_a_sel, alu_b_sel, alu_op, halted, instret};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  e, m;
            string t;
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, 64'(obs & m), 64'(e & m));
        end
    end

    // One clock cycle: queue the expectation for the current inputs, then
    // advance; retirements are counted from the expected pc_we strobe.
    task automatic cyc(input out_t x, input out_t m, input string phase);
        x.instret = exp_instret;
        exp_q.push_back(x);
        msk_q.push_back(m);
        tag_q.push_back($sformatf("%s_%08h", phase, ir));
        @(posedge clk);
        if (x.pc_we) exp_instret++;
        #1;
    endtask

    task automatic exec(input logic [31:0] instr, input int kind, input logic [1:0] a,
                        input logic b, input logic [3:0] op, input int if_wait,
                        input int mem_wait, input logic br);
        out_t x, m;
        m  = '1;
        ir = instr;
        for (int i = 0; i < if_wait; i++) begin
            imem_rdy = 1'b0;
            x = '0; x.imem_req = 1'b1;
            cyc(x, m, "if_wait");
        end
        imem_rdy = 1'b1;
        x = '0; x.imem_req = 1'b1; x.ir_we = 1'b1;
        cyc(x, m, "if");
        imem_rdy = 1'b0;
        x = '0;
        cyc(x, m, "id");
        if (kind == K_ILL) begin
            imem_rdy = 1'b1;
            for (int i = 0; i < 20; i++) begin
                x = '0; x.halted = 1'b1;
                cyc(x, m, "halt");
            end
            imem_rdy = 1'b0;
            return;
        end
        x = '0; x.alu_a_sel = a; x.alu_b_sel = b; x.alu_op = op;
        if (kind == K_BR || kind == K_JAL) begin
            m.alu_a_sel = '0; m.alu_b_sel = 1'b0; m.alu_op = '0;
        end
        if (kind == K_BR) begin
            br_taken = br;
            x.pc_we = 1'b1; x.pc_sel = br ? 2'd1 : 2'd0;
            cyc(x, m, "ex_br");
            br_taken = 1'b0;
            return;
        end
        cyc(x, m, "ex");
        if (kind == K_LOAD || kind == K_STORE) begin
            x.dmem_req = 1'b1;
            x.dmem_we  = (kind == K_STORE);
            for (int i = 0; i < mem_wait; i++) begin
                dmem_rdy = 1'b0;
                cyc(x, m, "mem_wait");
            end
            dmem_rdy = 1'b1;
            if (kind == K_STORE) x.pc_we = 1'b1;
            cyc(x, m, "mem");
            dmem_rdy = 1'b0;
            if (kind == K_STORE) return;
            x.dmem_req = 1'b0; x.dmem_we = 1'b0;
        end
        x.rf_we  = 1'b1;
        x.pc_we  = 1'b1;
        x.wb_sel = (kind == K_LOAD) ? 2'd1 : ((kind == K_JAL || kind == K_JALR) ? 2'd2 : 2'd0);
        x.pc_sel = (kind == K_JAL) ? 2'd1 : ((kind == K_JALR) ? 2'd2 : 2'd0);
        cyc(x, m, "wb");
    endtask

    task automatic do_reset();
        out_t x, m;
        m = '1;
        rstn = 1'b0;
        exp_instret = '0;
        x = '0;
        cyc(x, m, "rst");
        cyc(x, m, "rst");
        rstn = 1'b1;
        cyc(x, m, "init");
    endtask

    initial begin
        out_t x, m;
        n_checks = 0;
        n_errors = 0;
        exp_instret = '0;
        rstn = 1'b0;
        ir = '0;
        br_taken = 1'b0;
        imem_rdy = 1'b0;
        dmem_rdy = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        exec(32'h00500093, K_ALU,   2'd0, 1'b1, 4'd0, 0, 0, 1'b0); // addi x1,x0,5
        exec(32'h40208133, K_ALU,   2'd0, 1'b0, 4'd1, 2, 0, 1'b0); // sub, imem waits
        exec(32'h4030D093, K_ALU,   2'd0, 1'b1, 4'd7, 0, 0, 1'b0); // srai
        exec(32'hFFF00093, K_ALU,   2'd0, 1'b1, 4'd0, 0, 0, 1'b0); // addi -1: bit30 set, still ADD
        exec(32'h0020F1B3, K_ALU,   2'd0, 1'b0, 4'd2, 0, 0, 1'b0); // and
        exec(32'h0020B1B3, K_ALU,   2'd0, 1'b0, 4'd9, 0, 0, 1'b0); // sltu
        exec(32'h0020D1B3, K_ALU,   2'd0, 1'b0, 4'd6, 0, 0, 1'b0); // srl
        exec(32'h123450B7, K_ALU,   2'd2, 1'b1, 4'd0, 0, 0, 1'b0); // lui
        exec(32'h00001097, K_ALU,   2'd1, 1'b1, 4'd0, 0, 0, 1'b0); // auipc
        exec(32'h00208463, K_BR,    2'd0, 1'b0, 4'd0, 0, 0, 1'b1); // beq taken
        exec(32'h00208463, K_BR,    2'd0, 1'b0, 4'd0, 0, 0, 1'b0); // beq not taken
        exec(32'h0000A183, K_LOAD,  2'd0, 1'b1, 4'd0, 0, 3, 1'b0); // lw, 3 wait cycles
        exec(32'h0000A183, K_LOAD,  2'd0, 1'b1, 4'd0, 0, 0, 1'b0); // lw, zero wait
        exec(32'h0030A023, K_STORE, 2'd0, 1'b1, 4'd0, 0, 1, 1'b0); // sw
        exec(32'h0080006F, K_JAL,   2'd0, 1'b0, 4'd0, 0, 0, 1'b0); // jal
        exec(32'h000080E7, K_JALR,  2'd0, 1'b1, 4'd0, 0, 0, 1'b0); // jalr
        exec(32'hFFFFFFFF, K_ILL,   2'd0, 1'b0, 4'd0, 0, 0, 1'b0); // illegal -> HALT

        // Only reset leaves HALT; instret must clear as well.
        do_reset();
        exec(32'h00500093, K_ALU,   2'd0, 1'b1, 4'd0, 0, 0, 1'b0);

        // Reset asserted mid-IF: imem_req must drop within the same cycle.
        m = '1;
        imem_rdy = 1'b0;
        x = '0; x.imem_req = 1'b1;
        cyc(x, m, "if_hold");
        rstn = 1'b0;
        exp_instret = '0;
        x = '0;
        cyc(x, m, "rst_mid_if");
        rstn = 1'b1;
        cyc(x, m, "init2");
        exec(32'h0000A183, K_LOAD,  2'd0, 1'b1, 4'd0, 1, 0, 1'b0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the RV32I lab CPU.
- Sequences fetch, decode, execute, memory and writeback over the shared datapath: PC, IR, register file, immediate generator, ALU, branch comparator and data memory.
- Drives datapath muxes and write enables from the current state and IR.
- Handshakes with instruction and data memories; counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter instret

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
ir  in  32  current instruction register contents
br_taken  in  1  branch comparator result for ir's funct3 (valid in EX)
imem_rdy  in  1  instruction memory read data valid
dmem_rdy  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
ir_we  out  1  latch fetched word into IR
pc_we  out  1  update PC
pc_sel  out  2  0: pc+4, 1: pc+imm<<1 (branch/JAL), 2: (rs1+imm)&~1 (JALR)
rf_we  out  1  register file write
wb_sel  out  2  0: ALU result, 1: load data, 2: pc+4
alu_a_sel  out  2  0: rs1, 1: pc, 2: zero
alu_b_sel  out  1  0: rs2, 1: imm
alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
halted  out  1  sticky illegal-opcode halt flag
instret  out  CNT_W  retired instruction count

Behaviour:
- States: INIT, IF, ID, EX, MEM, WB, HALT. rstn=0 asynchronously forces INIT, instret=0, halted=0.
- All outputs are combinational decodes of state and ir. In INIT all strobes, selects and alu_op are 0. INIT always advances to IF after one cycle.
- IF:
  - imem_req=1 every cycle in IF.
  - On imem_rdy=1: ir_we=1 in that same cycle, go to ID.
  - Otherwise hold in IF with imem_req still asserted.
- ID: one cycle, no strobes.
  - Opcode not in {ALU, ALU_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR}: go to HALT.
  - Otherwise go to EX.
- EX: ALU controls held valid through EX/MEM/WB.
  - ALU: a=rs1, b=rs2. alu_op from funct3/funct7[5]; funct3=000 with f7[5]=1 gives SUB; funct3=101 with f7[5]=1 gives SRA.
  - ALU_IMM: b=imm, same decode, except funct3=000 is always ADD. SRAI uses f7[5].
  - LUI: a=zero, b=imm, ADD. AUIPC: a=pc, b=imm, ADD.
  - LOAD/STORE/JALR: a=rs1, b=imm, ADD.
  - BRANCH: pc_we=1, pc_sel = br_taken ? 1 : 0; instruction retires; go to IF.
  - LOAD/STORE go to MEM; all others go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 only for STORE. Hold MEM until dmem_rdy.
  - STORE with dmem_rdy: pc_we=1, pc_sel=0, retire, go to IF.
  - LOAD with dmem_rdy: go to WB.
- WB:
  - rf_we=1 and pc_we=1, single cycle, retire, go to IF.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_sel: 1 for JAL, 2 for JALR, else 0.
- HALT: absorbing; all strobes 0, halted=1. Only rstn exits.
- instret increments by 1 on every cycle with pc_we=1, modulo 2^CNT_W.
- Reset mid-access: request outputs drop in the same cycle as rstn falls. No pending-transaction tracking is required.
- CPI: ALU/LUI/AUIPC/JAL/JALR = 4, BRANCH = 3, STORE = 4, LOAD = 5, each with zero-wait memories (imem_rdy/dmem_rdy high in the first request cycle).

Test Plan:
- Reset, then imem_rdy=1 with ir=0x00500093 (addi x1,x0,5) -> INIT, IF, ID, EX(alu_b_sel=1, alu_op=0), WB(rf_we=1, wb_sel=0, pc_we=1, pc_sel=0); instret=1 after 5 cycles.
- ir=0x40208133 (sub x2,x1,x2) -> alu_op=1; ir=0x4030D093 (srai) -> alu_op=7, alu_b_sel=1.
- beq with br_taken=1 -> EX asserts pc_we with pc_sel=1, no rf_we. Same with br_taken=0 -> pc_sel=0. Both retire in 3 cycles.
- lw with dmem_rdy low for 3 cycles -> dmem_req held 4 MEM cycles with dmem_we=0, then WB with wb_sel=1. sw -> dmem_we=1, no WB state.
- jal (0x0080006F) -> WB: rf_we=1, wb_sel=2, pc_sel=1. jalr (0x000080E7) -> pc_sel=2.
- ir=0xFFFFFFFF -> HALT after ID, halted=1, imem_req stays 0 for 20 cycles. Pulse rstn low mid-IF -> INIT, instret=0, halted=0.
